// File: rtl/iq_freelist_if.sv
// Dispatch/issue-side bundle of the IQ free list.
//   allocReq_i  : per-lane allocate request (thermometer from lane 0)
//   freeIdx_o   : slot index offered to each dispatch lane
//   iqFull_o    : dispatch stall, fewer free slots than dispatch lanes
//   relValid_i  : per-port release valid
//   relIdx_i    : slot index released on each port
//   flush_i     : return every slot to the list
//   freeCnt_o   : number of free slots, 0..DEPTH
//   relErr_o    : sticky, a release group was dropped on overflow
interface iq_freelist_if #(
    parameter int unsigned INDEX          = 5,
    parameter int unsigned DISPATCH_WIDTH = 4,
    parameter int unsigned ISSUE_WIDTH    = 4
);
    logic [DISPATCH_WIDTH-1:0]            allocReq_i;
    logic [DISPATCH_WIDTH-1:0][INDEX-1:0] freeIdx_o;
    logic                                 iqFull_o;
    logic [ISSUE_WIDTH-1:0]               relValid_i;
    logic [ISSUE_WIDTH-1:0][INDEX-1:0]    relIdx_i;
    logic                                 flush_i;
    logic [INDEX:0]                       freeCnt_o;
    logic                                 relErr_o;

    modport master (
        output allocReq_i, relValid_i, relIdx_i, flush_i,
        input  freeIdx_o, iqFull_o, freeCnt_o, relErr_o
    );

    modport slave (
        input  allocReq_i, relValid_i, relIdx_i, flush_i,
        output freeIdx_o, iqFull_o, freeCnt_o, relErr_o
    );
endinterface

// File: rtl/iq_freelist.sv
// Issue-queue entry free list: circular FIFO of IQ slot indices with
// multi-lane allocate (dispatch), multi-port release (issue), a free
// count, dispatch stall and flush recovery.
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous active-low reset
//   fl    : slave side of iq_freelist_if (see interface for signals)
// freeIdx_o, iqFull_o and freeCnt_o depend on registered state only.
module iq_freelist #(
    parameter int unsigned DEPTH          = 32,
    parameter int unsigned INDEX          = 5,
    parameter int unsigned DISPATCH_WIDTH = 4,
    parameter int unsigned ISSUE_WIDTH    = 4
) (
    input  logic          clk,
    input  logic          reset,
    iq_freelist_if.slave  fl
);
    localparam int unsigned CNT_W = INDEX + 1;
    // One extra bit so count + releases never wraps before the overflow test.
    localparam int unsigned SUM_W = INDEX + 2;

    logic [INDEX-1:0] list_q [DEPTH];
    logic [INDEX-1:0] list_d [DEPTH];
    logic [INDEX-1:0] head_q, head_d;
    logic [INDEX-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             full_c;
    logic [CNT_W-1:0] n_alloc;
    logic [CNT_W-1:0] n_alloc_acc;
    logic [CNT_W-1:0] n_rel;
    logic [SUM_W-1:0] cnt_sum;
    logic             rel_ovf;
    logic [INDEX-1:0] rel_off;

    assign full_c = cnt_q < CNT_W'(DISPATCH_WIDTH);

    // Outputs straight from state: dispatch sees its indices in the request cycle.
    always_comb begin
        for (int k = 0; k < int'(DISPATCH_WIDTH); k++) begin
            fl.freeIdx_o[k] = list_q[head_q + INDEX'(k)];
        end
    end
    assign fl.iqFull_o  = full_c;
    assign fl.freeCnt_o = cnt_q;
    assign fl.relErr_o  = err_q;

    // Request populations; a non-thermometer allocate still advances by popcount.
    always_comb begin
        n_alloc = '0;
        for (int i = 0; i < int'(DISPATCH_WIDTH); i++) begin
            n_alloc = n_alloc + CNT_W'(fl.allocReq_i[i]);
        end
        n_rel = '0;
        for (int p = 0; p < int'(ISSUE_WIDTH); p++) begin
            n_rel = n_rel + CNT_W'(fl.relValid_i[p]);
        end
    end

    assign n_alloc_acc = full_c ? '0 : n_alloc;
    assign cnt_sum     = SUM_W'(cnt_q) - SUM_W'(n_alloc_acc) + SUM_W'(n_rel);
    assign rel_ovf     = cnt_sum > SUM_W'(DEPTH);

    // Next-state: flush wins; an overflowing release group is dropped whole
    // while the accepted allocate still applies.
    always_comb begin
        list_d  = list_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rel_off = '0;

        if (fl.flush_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                list_d[i] = INDEX'(i);
            end
            head_d = '0;
            tail_d = '0;
            cnt_d  = CNT_W'(DEPTH);
        end else begin
            head_d = head_q + INDEX'(n_alloc_acc);
            if (rel_ovf) begin
                err_d = 1'b1;
                cnt_d = cnt_q - n_alloc_acc;
            end else begin
                // Compact valid ports in ascending order onto the tail.
                for (int p = 0; p < int'(ISSUE_WIDTH); p++) begin
                    if (fl.relValid_i[p]) begin
                        list_d[tail_q + rel_off] = fl.relIdx_i[p];
                        rel_off = rel_off + INDEX'(1);
                    end
                end
                tail_d = tail_q + INDEX'(n_rel);
                cnt_d  = CNT_W'(cnt_sum);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                list_q[i] <= INDEX'(i);
            end
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= CNT_W'(DEPTH);
            err_q  <= 1'b0;
        end else begin
            list_q <= list_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end
endmodule

// File: tb/tb_iq_freelist.sv
// Directed, table-driven bench for iq_freelist.
module tb_iq_freelist;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned INDEX = 5;
    localparam int unsigned DW    = 4;
    localparam int unsigned IW    = 4;

    typedef logic [3:0][4:0] idx4_t;

    typedef struct packed {
        logic [3:0] alloc;
        logic [3:0] relv;
        idx4_t      relidx;
        logic       flush;
        logic       chk_idx;
        logic [5:0] cnt;
        logic       full;
        idx4_t      idx;
        logic       err;
    } vec_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    vec_t tbl [40];
    int   n_vec;

    iq_freelist_if #(.INDEX(INDEX), .DISPATCH_WIDTH(DW), .ISSUE_WIDTH(IW)) bus ();

    iq_freelist #(.DEPTH(DEPTH), .INDEX(INDEX), .DISPATCH_WIDTH(DW), .ISSUE_WIDTH(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .fl    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic idx4_t l4(input int a, input int b, input int c, input int d);
        idx4_t r;
        r[0] = 5'(a);
        r[1] = 5'(b);
        r[2] = 5'(c);
        r[3] = 5'(d);
        return r;
    endfunction

    task automatic add(input logic [3:0] al, input logic [3:0] rv, input idx4_t ri,
                       input logic fl, input logic ci, input int cnt, input logic full,
                       input idx4_t idx, input logic err);
        vec_t v;
        v.alloc   = al;
        v.relv    = rv;
        v.relidx  = ri;
        v.flush   = fl;
        v.chk_idx = ci;
        v.cnt     = 6'(cnt);
        v.full    = full;
        v.idx     = idx;
        v.err     = err;
        tbl[n_vec] = v;
        n_vec++;
    endtask

    task automatic chk(input string nm, input int v, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d: got 0x%0h want 0x%0h", nm, v, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int v, input int cnt, input logic full,
                           input idx4_t idx, input logic err, input logic ci);
        chk({tag, "_cnt"},  v, 32'(bus.freeCnt_o), 32'(cnt));
        chk({tag, "_full"}, v, 32'(bus.iqFull_o),  32'(full));
        chk({tag, "_err"},  v, 32'(bus.relErr_o),  32'(err));
        if (ci) chk({tag, "_idx"}, v, 32'(bus.freeIdx_o), 32'(idx));
    endtask

    task automatic drive_idle();
        bus.allocReq_i = '0;
        bus.relValid_i = '0;
        bus.relIdx_i   = '0;
        bus.flush_i    = 1'b0;
    endtask

    initial begin
        vec_t  v;
        vec_t  prev;
        idx4_t junk;
        total = 0;
        bad   = 0;
        n_vec = 0;
        junk  = l4(0, 0, 0, 0);

        // Post-reset idle, then 8 full-width allocates down to empty.
        add(4'b0000, 4'b0000, junk, 0, 1, 32, 0, l4(0, 1, 2, 3), 0);
        for (int k = 1; k <= 7; k++)
            add(4'b1111, 4'b0000, junk, 0, 1, 32 - 4 * k, 0,
                l4(4 * k, 4 * k + 1, 4 * k + 2, 4 * k + 3), 0);
        add(4'b1111, 4'b0000, junk, 0, 0, 0, 1, junk, 0);
        add(4'b1111, 4'b0000, junk, 0, 0, 0, 1, junk, 0);
        // Release while empty (alloc ignored), ports 1 and 3 compacted.
        add(4'b1111, 4'b1010, l4(31, 5, 30, 9), 0, 0, 2, 1, junk, 0);
        add(4'b0000, 4'b0011, l4(12, 13, 0, 0), 0, 1, 4, 0, l4(5, 9, 12, 13), 0);
        // Flush, then walk head to 30 with count 8.
        add(4'b0000, 4'b0000, junk, 1, 1, 32, 0, l4(0, 1, 2, 3), 0);
        for (int k = 1; k <= 7; k++)
            add(4'b1111, 4'b0000, junk, 0, 1, 32 - 4 * k, 0,
                l4(4 * k, 4 * k + 1, 4 * k + 2, 4 * k + 3), 0);
        add(4'b0011, 4'b0000, junk, 0, 0, 2, 1, junk, 0);
        add(4'b0000, 4'b1111, l4(16, 17, 18, 19), 0, 1, 6, 0, l4(30, 31, 16, 17), 0);
        add(4'b0000, 4'b0011, l4(20, 21, 0, 0), 0, 1, 8, 0, l4(30, 31, 16, 17), 0);
        // Wrap with simultaneous allocate and release.
        add(4'b0011, 4'b1101, l4(24, 3, 25, 26), 0, 1, 9, 0, l4(16, 17, 18, 19), 0);
        // Overflow cases.
        add(4'b0000, 4'b0000, junk, 1, 1, 32, 0, l4(0, 1, 2, 3), 0);
        add(4'b0001, 4'b0000, junk, 0, 1, 31, 0, l4(1, 2, 3, 4), 0);
        add(4'b0000, 4'b0101, l4(7, 0, 8, 0), 0, 1, 31, 0, l4(1, 2, 3, 4), 1);
        add(4'b0000, 4'b0001, l4(0, 0, 0, 0), 0, 1, 32, 0, l4(1, 2, 3, 4), 1);
        add(4'b0001, 4'b0011, l4(5, 6, 0, 0), 0, 1, 31, 0, l4(2, 3, 4, 5), 1);
        // Flush priority over allocate and release; sticky error kept.
        add(4'b1111, 4'b1111, l4(10, 11, 12, 13), 1, 1, 32, 0, l4(0, 1, 2, 3), 1);
        add(4'b1111, 4'b0000, junk, 0, 1, 28, 0, l4(4, 5, 6, 7), 1);

        // Reset values while reset is held.
        reset = 1'b0;
        drive_idle();
        #7;
        chk_all("rst", -1, 32, 0, l4(0, 1, 2, 3), 0, 1);
        @(negedge clk);
        reset = 1'b1;

        prev = tbl[0];
        for (int i = 0; i < n_vec; i++) begin
            v = tbl[i];
            @(negedge clk);
            bus.allocReq_i = v.alloc;
            bus.relValid_i = v.relv;
            bus.relIdx_i   = v.relidx;
            bus.flush_i    = v.flush;
            #1;
            // Outputs must not move with the inputs before the edge.
            if (i > 0) chk_all("pre", i, int'(prev.cnt), prev.full, prev.idx, prev.err, prev.chk_idx);
            @(posedge clk);
            #1;
            chk_all("post", i, int'(v.cnt), v.full, v.idx, v.err, v.chk_idx);
            prev = v;
        end

        // Asynchronous reset mid-cycle from a non-reset state.
        @(negedge clk);
        drive_idle();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk_all("async_rst", -1, 32, 0, l4(0, 1, 2, 3), 0, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_all("after_rst", -1, 32, 0, l4(0, 1, 2, 3), 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
